// File: rtl/rf_pkg.sv
// Shared register-file geometry used by the writeback scheduler and its buffer.
package rf_pkg;
  localparam int REG_W    = 5;
  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam logic [REG_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/wb_hold_buf.sv
// One-entry skid register holding a multi-cycle result that lost the
// register-file write port to the pipeline.
module wb_hold_buf
  import rf_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [REG_W-1:0] load_rd,
  input  logic [XLEN-1:0]  load_data,
  input  logic             drain,
  output logic             buf_valid,
  output logic [REG_W-1:0] buf_rd,
  output logic [XLEN-1:0]  buf_data
);

  // Capture on load, empty on drain; load and drain never coincide because the
  // scheduler refuses new results while the buffer is occupied.
  always_ff @(posedge clk) begin
    if (rst) begin
      buf_valid <= 1'b0;
      buf_rd    <= REG_ZERO;
      buf_data  <= '0;
    end else if (load) begin
      buf_valid <= 1'b1;
      buf_rd    <= load_rd;
      buf_data  <= load_data;
    end else if (drain) begin
      buf_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/reg_wb_scheduler.sv
// Register-file write-port owner: arbitrates pipeline writeback against
// out-of-order multi-cycle results and tracks busy destinations for decode.
module reg_wb_scheduler
  import rf_pkg::*;
#(
  parameter int MAX_PENDING = 4,
  parameter int CNT_W       = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                pipe_wen,
  input  logic [REG_W-1:0]    pipe_rd,
  input  logic [XLEN-1:0]     pipe_data,
  input  logic                issue_valid,
  input  logic [REG_W-1:0]    issue_rd,
  output logic                issue_ready,
  input  logic                mc_valid,
  input  logic [REG_W-1:0]    mc_rd,
  input  logic [XLEN-1:0]     mc_data,
  output logic                mc_ready,
  input  logic [REG_W-1:0]    chk_a,
  input  logic [REG_W-1:0]    chk_b,
  output logic                hazard_a,
  output logic                hazard_b,
  output logic                rf_w_en,
  output logic [REG_W-1:0]    rf_req_w,
  output logic [XLEN-1:0]     rf_data_w,
  output logic [NUM_REGS-1:0] busy_mask,
  output logic                err
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_PENDING);

  logic [NUM_REGS-1:0] busy;
  logic [CNT_W-1:0]    count;
  logic                buf_valid;
  logic [REG_W-1:0]    buf_rd;
  logic [XLEN-1:0]     buf_data;
  logic                mc_accept;
  logic                pipe_sel;
  logic                buf_sel;
  logic                mc_sel;
  logic                buf_load;
  logic                set_en;
  logic                clr_tracked;
  logic [REG_W-1:0]    clr_rd;
  logic                err_pipe;
  logic                err_mc;
  logic                err_under;

  wb_hold_buf u_hold_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (buf_load),
    .load_rd   (mc_rd),
    .load_data (mc_data),
    .drain     (buf_sel),
    .buf_valid (buf_valid),
    .buf_rd    (buf_rd),
    .buf_data  (buf_data)
  );

  // Write-port arbitration: pipeline first, then a parked result, then a fresh
  // multi-cycle result; a reset cycle never writes so a parked result is dropped.
  always_comb begin
    mc_ready  = en && !buf_valid;
    mc_accept = mc_valid && mc_ready;
    pipe_sel  = en && !rst && pipe_wen && (pipe_rd != REG_ZERO);
    buf_sel   = en && !rst && !pipe_sel && buf_valid;
    mc_sel    = en && !rst && !pipe_sel && !buf_valid && mc_accept && (mc_rd != REG_ZERO);
    buf_load  = mc_accept && pipe_sel && (mc_rd != REG_ZERO);
    rf_w_en   = pipe_sel || buf_sel || mc_sel;
    rf_req_w  = REG_ZERO;
    rf_data_w = '0;
    if (pipe_sel) begin
      rf_req_w  = pipe_rd;
      rf_data_w = pipe_data;
    end else if (buf_sel) begin
      rf_req_w  = buf_rd;
      rf_data_w = buf_data;
    end else if (mc_sel) begin
      rf_req_w  = mc_rd;
      rf_data_w = mc_data;
    end
  end

  // Scoreboard queries: issue admission uses the busy state before this
  // cycle's clear, and protocol violations are only judged while running.
  always_comb begin
    issue_ready = en && !busy[issue_rd] && ((count < MAX_CNT) || (issue_rd == REG_ZERO));
    set_en      = issue_valid && issue_ready && (issue_rd != REG_ZERO);
    clr_rd      = buf_sel ? buf_rd : mc_rd;
    clr_tracked = (buf_sel || mc_sel) && busy[clr_rd];
    err_pipe    = pipe_sel && busy[pipe_rd];
    err_mc      = en && mc_valid && (mc_rd != REG_ZERO) && !busy[mc_rd];
    err_under   = clr_tracked && !set_en && (count == '0);
    hazard_a    = busy[chk_a];
    hazard_b    = busy[chk_b];
    busy_mask   = busy;
  end

  // Busy bits, pending count and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy  <= '0;
      count <= '0;
      err   <= 1'b0;
    end else begin
      if (clr_tracked) busy[clr_rd] <= 1'b0;
      if (set_en) busy[issue_rd] <= 1'b1;
      if (set_en && !clr_tracked) begin
        count <= count + 1'b1;
      end else if (clr_tracked && !set_en && (count != '0)) begin
        count <= count - 1'b1;
      end
      if (err_pipe || err_mc || err_under) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_wb_scheduler.sv
// Directed bench for reg_wb_scheduler with a per-cycle reference model.
module tb_reg_wb_scheduler;

  localparam int MAXP = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        pipe_wen;
  logic [4:0]  pipe_rd;
  logic [31:0] pipe_data;
  logic        issue_valid;
  logic [4:0]  issue_rd;
  logic        issue_ready;
  logic        mc_valid;
  logic [4:0]  mc_rd;
  logic [31:0] mc_data;
  logic        mc_ready;
  logic [4:0]  chk_a;
  logic [4:0]  chk_b;
  logic        hazard_a;
  logic        hazard_b;
  logic        rf_w_en;
  logic [4:0]  rf_req_w;
  logic [31:0] rf_data_w;
  logic [31:0] busy_mask;
  logic        err;

  int n_cmp  = 0;
  int n_fail = 0;
  bit cmp_on = 0;

  // Reference state: set of busy registers, parked result, sticky error.
  bit [31:0] m_busy = '0;
  bit        m_bv   = 0;
  bit [4:0]  m_brd  = '0;
  bit [31:0] m_bdat = '0;
  bit        m_err  = 0;

  typedef struct {
    bit        wen;
    bit [4:0]  rd;
    bit [31:0] data;
    bit        mc_rdy;
    bit        iss_rdy;
    bit        from_buf;
    bit        from_mc;
    bit        pipe_w;
  } exp_t;

  reg_wb_scheduler #(.MAX_PENDING(MAXP), .CNT_W(3)) dut (
    .clk(clk), .rst(rst), .en(en),
    .pipe_wen(pipe_wen), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .mc_valid(mc_valid), .mc_rd(mc_rd), .mc_data(mc_data), .mc_ready(mc_ready),
    .chk_a(chk_a), .chk_b(chk_b), .hazard_a(hazard_a), .hazard_b(hazard_b),
    .rf_w_en(rf_w_en), .rf_req_w(rf_req_w), .rf_data_w(rf_data_w),
    .busy_mask(busy_mask), .err(err)
  );

  always #5 clk = ~clk;

  // Expected outputs from the write-priority and admission rules.
  function automatic exp_t predict();
    exp_t e;
    int   pending;
    e = '{default: 0};
    pending   = $countones(m_busy);
    e.mc_rdy  = en && !m_bv;
    e.iss_rdy = en && !m_busy[issue_rd] && (pending < MAXP || issue_rd == 0);
    e.pipe_w  = en && !rst && pipe_wen && pipe_rd != 0;
    if (e.pipe_w) begin
      e.wen = 1; e.rd = pipe_rd; e.data = pipe_data;
    end else if (en && !rst && m_bv) begin
      e.wen = 1; e.rd = m_brd; e.data = m_bdat; e.from_buf = 1;
    end else if (en && !rst && mc_valid && mc_rd != 0) begin
      e.wen = 1; e.rd = mc_rd; e.data = mc_data; e.from_mc = 1;
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance the model by one clock.
  always @(posedge clk) begin
    exp_t e;
    e = predict();
    if (rst) begin
      m_busy = '0; m_bv = 0; m_err = 0;
    end else if (en) begin
      if (pipe_wen && pipe_rd != 0 && m_busy[pipe_rd]) m_err = 1;
      if (mc_valid && mc_rd != 0 && !m_busy[mc_rd]) m_err = 1;
      if (e.from_buf || e.from_mc) m_busy[e.rd] = 0;
      if (e.from_buf) m_bv = 0;
      if (e.mc_rdy && mc_valid && mc_rd != 0 && e.pipe_w) begin
        m_bv = 1; m_brd = mc_rd; m_bdat = mc_data;
      end
      if (issue_valid && e.iss_rdy && issue_rd != 0) m_busy[issue_rd] = 1;
      m_busy[0] = 0;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    exp_t e;
    if (cmp_on) begin
      e = predict();
      checkOutput("m_rf_w_en", 32'(rf_w_en), 32'(e.wen));
      if (e.wen) begin
        checkOutput("m_rf_req_w", 32'(rf_req_w), 32'(e.rd));
        checkOutput("m_rf_data_w", rf_data_w, e.data);
      end
      checkOutput("m_mc_ready", 32'(mc_ready), 32'(e.mc_rdy));
      checkOutput("m_issue_ready", 32'(issue_ready), 32'(e.iss_rdy));
      checkOutput("m_hazard_a", 32'(hazard_a), 32'(m_busy[chk_a]));
      checkOutput("m_hazard_b", 32'(hazard_b), 32'(m_busy[chk_b]));
      checkOutput("m_busy_mask", busy_mask, m_busy);
      checkOutput("m_err", 32'(err), 32'(m_err));
    end
  end

  task automatic applyStimulus(input int r, input int e, input int pw, input int prd,
                               input logic [31:0] pd, input int iv, input int ird,
                               input int mv, input int mrd, input logic [31:0] md,
                               input int ca, input int cb);
    @(posedge clk);
    #1;
    rst = r[0]; en = e[0];
    pipe_wen = pw[0]; pipe_rd = 5'(prd); pipe_data = pd;
    issue_valid = iv[0]; issue_rd = 5'(ird);
    mc_valid = mv[0]; mc_rd = 5'(mrd); mc_data = md;
    chk_a = 5'(ca); chk_b = 5'(cb);
    @(negedge clk);
  endtask

  initial begin
    rst = 1; en = 1; pipe_wen = 0; pipe_rd = 0; pipe_data = 0;
    issue_valid = 0; issue_rd = 0; mc_valid = 0; mc_rd = 0; mc_data = 0;
    chk_a = 0; chk_b = 0;
    $display("[TB] start");
    applyStimulus(1, 1, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0);
    applyStimulus(1, 1, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0);
    cmp_on = 1;
    // Idle after reset
    applyStimulus(0, 1, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0);
    checkOutput("reset_busy", busy_mask, 32'h0);
    checkOutput("reset_wen", 32'(rf_w_en), 32'd0);
    checkOutput("reset_mc_ready", 32'(mc_ready), 32'd1);
    checkOutput("reset_issue_ready", 32'(issue_ready), 32'd1);
    checkOutput("reset_err", 32'(err), 32'd0);
    // Issue rd=5 then direct multi-cycle return
    applyStimulus(0, 1, 0, 0, 32'h0, 1, 5, 0, 0, 32'h0, 5, 0);
    checkOutput("iss5_ready", 32'(issue_ready), 32'd1);
    applyStimulus(0, 1, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 5, 0);
    checkOutput("busy5_set", busy_mask, 32'h20);
    checkOutput("haz5", 32'(hazard_a), 32'd1);
    applyStimulus(0, 1, 0, 0, 32'h0, 0, 0, 1, 5, 32'hDEADBEEF, 5, 0);
    checkOutput("direct_wen", 32'(rf_w_en), 32'd1);
    checkOutput("direct_rd", 32'(rf_req_w), 32'd5);
    checkOutput("direct_data", rf_data_w, 32'hDEADBEEF);
    checkOutput("haz5_during", 32'(hazard_a), 32'd1);
    applyStimulus(0, 1, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 5, 0);
    checkOutput("busy5_clr", busy_mask, 32'h0);
    // Collision: mc result parked behind pipeline write
    applyStimulus(0, 1, 0, 0, 32'h0, 1, 7, 0, 0, 32'h0, 7, 0);
    applyStimulus(0, 1, 1, 3, 32'h22, 0, 0, 1, 7, 32'h11, 7, 0);
    checkOutput("coll_rd", 32'(rf_req_w), 32'd3);
    checkOutput("coll_data", rf_data_w, 32'h22);
    applyStimulus(0, 1, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 7, 0);
    checkOutput("buf_mc_ready", 32'(mc_ready), 32'd0);
    checkOutput("buf_rd", 32'(rf_req_w), 32'd7);
    checkOutput("buf_data", rf_data_w, 32'h11);
    checkOutput("buf_busy7", busy_mask, 32'h80);
    applyStimulus(0, 1, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 7, 0);
    checkOutput("busy7_clr", busy_mask, 32'h0);
    // Fill pending slots with 1..4
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(0, 1, 0, 0, 32'h0, 1, i, 0, 0, 32'h0, 0, 4);
      checkOutput("fill_ready", 32'(issue_ready), 32'd1);
    end
    applyStimulus(0, 1, 0, 0, 32'h0, 1, 9, 0, 0, 32'h0, 0, 4);
    checkOutput("full_refuse", 32'(issue_ready), 32'd0);
    checkOutput("full_busy", busy_mask, 32'h1E);
    applyStimulus(0, 1, 0, 0, 32'h0, 1, 2, 0, 0, 32'h0, 0, 4);
    checkOutput("waw_refuse", 32'(issue_ready), 32'd0);
    applyStimulus(0, 1, 0, 0, 32'h0, 1, 9, 1, 1, 32'h101, 0, 4);
    checkOutput("preclear_refuse", 32'(issue_ready), 32'd0);
    applyStimulus(0, 1, 0, 0, 32'h0, 1, 9, 0, 0, 32'h0, 0, 4);
    checkOutput("after_clear_accept", 32'(issue_ready), 32'd1);
    // Park a result then freeze
    applyStimulus(0, 1, 1, 10, 32'hAA, 0, 0, 1, 2, 32'h202, 2, 9);
    applyStimulus(0, 0, 0, 0, 32'h0, 1, 11, 0, 0, 32'h0, 2, 9);
    checkOutput("frz_wen", 32'(rf_w_en), 32'd0);
    checkOutput("frz_issue", 32'(issue_ready), 32'd0);
    checkOutput("frz_haz", 32'(hazard_a), 32'd1);
    applyStimulus(0, 0, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 2, 9);
    checkOutput("frz_busy", busy_mask, 32'h21C);
    applyStimulus(0, 1, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 2, 9);
    checkOutput("thaw_rd", 32'(rf_req_w), 32'd2);
    checkOutput("thaw_data", rf_data_w, 32'h202);
    applyStimulus(0, 1, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 2, 9);
    checkOutput("thaw_busy", busy_mask, 32'h218);
    // Reset with a parked result
    applyStimulus(0, 1, 1, 10, 32'hAA, 0, 0, 1, 3, 32'h303, 3, 0);
    applyStimulus(1, 1, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 3, 0);
    checkOutput("rst_no_write", 32'(rf_w_en), 32'd0);
    applyStimulus(0, 1, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 3, 0);
    checkOutput("rst_busy", busy_mask, 32'h0);
    checkOutput("rst_drop", 32'(rf_w_en), 32'd0);
    // Unsolicited result raises sticky error
    applyStimulus(0, 1, 0, 0, 32'h0, 0, 0, 1, 12, 32'hC, 0, 0);
    checkOutput("err_before", 32'(err), 32'd0);
    applyStimulus(0, 1, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0);
    checkOutput("err_set", 32'(err), 32'd1);
    applyStimulus(0, 1, 0, 0, 32'h0, 1, 0, 0, 0, 32'h0, 0, 0);
    checkOutput("rd0_ready", 32'(issue_ready), 32'd1);
    checkOutput("rd0_haz", 32'(hazard_a), 32'd0);
    applyStimulus(0, 1, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0);
    checkOutput("rd0_busy", busy_mask, 32'h0);
    checkOutput("err_sticky", 32'(err), 32'd1);
    applyStimulus(1, 1, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0);
    applyStimulus(0, 1, 0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0, 0);
    checkOutput("err_cleared", 32'(err), 32'd0);
    cmp_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
